// File: rtl/frac_clk_div_prog.sv
// Runtime-programmable fractional clock divider: clk_out averages M/N clk_in cycles per period.
// Long (D+1) periods are spread through each N-period frame by an accumulator; new configs swap at a period boundary.
module frac_clk_div_prog #(
  parameter int W     = 8,
  parameter int DEF_M = 87,
  parameter int DEF_N = 10
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] cfg_m,
  input  logic [W-1:0] cfg_n,
  input  logic         cfg_load,
  output logic         cfg_busy,
  output logic         cfg_err,
  output logic         clk_out,
  output logic         frame_tick
);

  localparam logic [W-1:0] RST_N    = W'(DEF_N);
  localparam logic [W-1:0] RST_D    = W'(DEF_M / DEF_N);
  localparam logic [W-1:0] RST_R    = W'(DEF_M % DEF_N);
  localparam logic [W-1:0] DIV_LAST = W'(W - 1);
  localparam logic [W-1:0] ONE      = W'(1);

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_CHECK,
    CFG_DIV,
    CFG_PEND
  } cfg_state_t;

  cfg_state_t   cfg_state;
  logic [W-1:0] req_m;
  logic [W-1:0] req_n;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic [W-1:0] div_cnt;
  logic [W:0]   div_trial;
  logic         div_fit;
  logic [W-1:0] div_rem_next;
  logic         req_bad;

  logic [W-1:0] shd_n;
  logic [W-1:0] shd_d;
  logic [W-1:0] shd_r;

  logic [W-1:0] act_n;
  logic [W-1:0] act_d;
  logic [W-1:0] act_r;

  logic         running;
  logic [W-1:0] pcnt;
  logic [W-1:0] p_len;
  logic [W-1:0] p_half;
  logic [W-1:0] acc;
  logic [W-1:0] fcnt;

  logic         last_cyc;
  logic         swap_now;
  logic [W-1:0] use_n;
  logic [W-1:0] use_d;
  logic [W-1:0] use_r;
  logic         frame_wrap;
  logic [W-1:0] base_acc;
  logic [W-1:0] next_fcnt;
  logic [W:0]   acc_sum;
  logic         is_long;
  logic [W-1:0] next_len;
  logic [W-1:0] next_acc;

  assign last_cyc = running && (pcnt == p_len - ONE);
  // Swap only between periods so no single period mixes old and new settings.
  assign swap_now = (cfg_state == CFG_PEND) && (!running || last_cyc);

  assign req_bad      = (req_n == '0) || ({1'b0, req_m} < {req_n, 1'b0});
  assign div_trial    = {div_r, div_q[W-1]};
  assign div_fit      = div_trial >= {1'b0, req_n};
  assign div_rem_next = div_fit ? W'(div_trial - {1'b0, req_n}) : div_trial[W-1:0];

  always_comb begin
    use_n = act_n;
    use_d = act_d;
    use_r = act_r;
    if (swap_now) begin
      use_n = shd_n;
      use_d = shd_d;
      use_r = shd_r;
    end
    frame_wrap = !running || swap_now || (fcnt == act_n - ONE);
    base_acc   = frame_wrap ? '0 : acc;
    next_fcnt  = frame_wrap ? '0 : fcnt + ONE;
    acc_sum    = {1'b0, base_acc} + {1'b0, use_r};
    is_long    = acc_sum >= {1'b0, use_n};
    next_len   = is_long ? use_d + ONE : use_d;
    next_acc   = is_long ? W'(acc_sum - {1'b0, use_n}) : acc_sum[W-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cfg_state <= CFG_IDLE;
      cfg_busy  <= 1'b0;
      cfg_err   <= 1'b0;
      req_m     <= '0;
      req_n     <= '0;
      div_q     <= '0;
      div_r     <= '0;
      div_cnt   <= '0;
      shd_n     <= RST_N;
      shd_d     <= RST_D;
      shd_r     <= RST_R;
    end else begin
      cfg_err <= 1'b0;
      case (cfg_state)
        CFG_IDLE: begin
          if (cfg_load) begin
            req_m     <= cfg_m;
            req_n     <= cfg_n;
            cfg_busy  <= 1'b1;
            cfg_state <= CFG_CHECK;
          end
        end
        CFG_CHECK: begin
          if (req_bad) begin
            cfg_err   <= 1'b1;
            cfg_busy  <= 1'b0;
            cfg_state <= CFG_IDLE;
          end else begin
            div_q     <= req_m;
            div_r     <= '0;
            div_cnt   <= '0;
            cfg_state <= CFG_DIV;
          end
        end
        CFG_DIV: begin
          // Restoring divide: one quotient bit per cycle, MSB first.
          div_q   <= {div_q[W-2:0], div_fit};
          div_r   <= div_rem_next;
          div_cnt <= div_cnt + ONE;
          if (div_cnt == DIV_LAST) begin
            shd_n     <= req_n;
            shd_d     <= {div_q[W-2:0], div_fit};
            shd_r     <= div_rem_next;
            cfg_state <= CFG_PEND;
          end
        end
        CFG_PEND: begin
          if (swap_now) begin
            cfg_busy  <= 1'b0;
            cfg_state <= CFG_IDLE;
          end
        end
        default: cfg_state <= CFG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      act_n      <= RST_N;
      act_d      <= RST_D;
      act_r      <= RST_R;
      running    <= 1'b0;
      pcnt       <= '0;
      p_len      <= RST_D;
      p_half     <= '0;
      acc        <= '0;
      fcnt       <= '0;
      clk_out    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (swap_now) begin
        act_n <= shd_n;
        act_d <= shd_d;
        act_r <= shd_r;
      end
      frame_tick <= 1'b0;
      if (running && !last_cyc) begin
        pcnt    <= pcnt + ONE;
        clk_out <= (pcnt + ONE) < p_half;
      end else if (en) begin
        // Period start: the first cycle is already high, so the rise is registered on this edge.
        running    <= 1'b1;
        pcnt       <= '0;
        p_len      <= next_len;
        p_half     <= next_len >> 1;
        acc        <= next_acc;
        fcnt       <= next_fcnt;
        clk_out    <= (next_len >> 1) != '0;
        frame_tick <= next_fcnt == '0;
      end else begin
        running <= 1'b0;
        pcnt    <= '0;
        acc     <= '0;
        fcnt    <= '0;
        clk_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frac_clk_div_prog.sv
// Testbench for frac_clk_div_prog: a queue-based period model checked every cycle,
// plus directed scenarios with hand-computed period/duty expectations and a randomized phase.
module tb_frac_clk_div_prog;

  localparam int W     = 8;
  localparam int DEF_M = 87;
  localparam int DEF_N = 10;

  logic         clk_in = 1'b0;
  logic         rst;
  logic         en;
  logic         cfg_load;
  logic [W-1:0] cfg_m;
  logic [W-1:0] cfg_n;
  logic         cfg_busy;
  logic         cfg_err;
  logic         clk_out;
  logic         frame_tick;

  int n_compared   = 0;
  int n_mismatched = 0;

  frac_clk_div_prog #(.W(W), .DEF_M(DEF_M), .DEF_N(DEF_N)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg_m     (cfg_m),
    .cfg_n     (cfg_n),
    .cfg_load  (cfg_load),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .frame_tick(frame_tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst_v, input bit en_v, input bit load_v,
                               input int m_v, input int n_v);
    rst      = rst_v;
    en       = en_v;
    cfg_load = load_v;
    cfg_m    = W'(m_v);
    cfg_n    = W'(n_v);
  endtask

  // Reference model: the active config defines a whole period as a list of output bits.
  typedef enum {REQ_NONE, REQ_BAD, REQ_OK} req_t;
  req_t req_kind = REQ_NONE;
  int   m_cur = DEF_M;
  int   n_cur = DEF_N;
  int   k_pos = 0;
  int   req_m = 0;
  int   req_n = 0;
  int   req_edge = 0;
  int   edge_cnt = 0;
  bit   running_m = 0;
  bit   per_q[$];
  bit   exp_clk = 0;
  bit   exp_tick = 0;
  bit   exp_busy = 0;
  bit   exp_err = 0;
  bit   check_en = 0;

  always @(posedge clk_in) begin : ref_model
    bit swap_m;
    bit busy_old;
    bit long_p;
    int d_m;
    int r_m;
    int p_m;
    edge_cnt++;
    if (!rst) begin
      m_cur = DEF_M; n_cur = DEF_N; k_pos = 0;
      running_m = 0; per_q.delete(); req_kind = REQ_NONE;
      exp_clk = 0; exp_tick = 0; exp_busy = 0; exp_err = 0;
      check_en = 1;
    end else begin
      swap_m   = 0;
      busy_old = exp_busy;
      exp_err  = 0;
      if (req_kind == REQ_BAD && edge_cnt == req_edge + 1) begin
        exp_err = 1; exp_busy = 0; req_kind = REQ_NONE;
      end else if (req_kind == REQ_OK && edge_cnt >= req_edge + W + 2 &&
                   (!running_m || per_q.size() == 1)) begin
        swap_m = 1; exp_busy = 0; req_kind = REQ_NONE;
      end
      if (!busy_old && cfg_load) begin
        req_m    = int'(cfg_m);
        req_n    = int'(cfg_n);
        req_edge = edge_cnt;
        exp_busy = 1;
        req_kind = (req_n == 0 || req_m < 2 * req_n) ? REQ_BAD : REQ_OK;
      end
      if (running_m && per_q.size() > 1) begin
        void'(per_q.pop_front());
        exp_clk  = per_q[0];
        exp_tick = 0;
      end else begin
        if (swap_m) begin
          m_cur = req_m; n_cur = req_n;
        end
        if (en) begin
          k_pos  = (!running_m || swap_m) ? 0 : (k_pos + 1) % n_cur;
          d_m    = m_cur / n_cur;
          r_m    = m_cur % n_cur;
          long_p = ((k_pos + 1) * r_m) / n_cur > (k_pos * r_m) / n_cur;
          p_m    = long_p ? d_m + 1 : d_m;
          per_q.delete();
          for (int i = 0; i < p_m; i++) per_q.push_back(i < p_m / 2);
          running_m = 1;
          exp_clk   = per_q[0];
          exp_tick  = (k_pos == 0);
        end else begin
          running_m = 0; per_q.delete(); k_pos = 0;
          exp_clk = 0; exp_tick = 0;
        end
      end
    end
  end

  always @(negedge clk_in) begin : compare
    if (check_en) begin
      checkOutput("clk_out",    int'(clk_out),    int'(exp_clk));
      checkOutput("frame_tick", int'(frame_tick), int'(exp_tick));
      checkOutput("cfg_busy",   int'(cfg_busy),   int'(exp_busy));
      checkOutput("cfg_err",    int'(cfg_err),    int'(exp_err));
    end
  end

  // Measures rise-to-rise periods, high times and frame_tick spacing straight off the DUT pins.
  int cyc = 0;
  int last_rise = -1;
  int last_tick = -1;
  int high_cnt = 0;
  bit high_valid = 0;
  bit prev_clk = 0;
  bit prev_tick = 0;
  int gaps[$];
  int tick_gaps[$];
  int high_lens[$];

  always @(negedge clk_in) begin : monitor
    cyc++;
    if (clk_out === 1'b1 && !prev_clk) begin
      if (last_rise >= 0) gaps.push_back(cyc - last_rise);
      last_rise  = cyc;
      high_cnt   = 1;
      high_valid = 1;
    end else if (clk_out === 1'b1) begin
      high_cnt++;
    end else if (prev_clk && high_valid) begin
      high_lens.push_back(high_cnt);
    end
    if (frame_tick === 1'b1 && !prev_tick) begin
      if (last_tick >= 0) tick_gaps.push_back(cyc - last_tick);
      last_tick = cyc;
    end
    prev_clk  = (clk_out === 1'b1);
    prev_tick = (frame_tick === 1'b1);
  end

  task automatic clearMonitor();
    #1;
    gaps.delete();
    tick_gaps.delete();
    high_lens.delete();
    last_rise  = -1;
    last_tick  = -1;
    high_valid = 0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic checkEntry(input string name, input int which, input int idx, input int expected);
    int actual;
    actual = -1;
    case (which)
      0:       if (idx < gaps.size())      actual = gaps[idx];
      1:       if (idx < tick_gaps.size()) actual = tick_gaps[idx];
      default: if (idx < high_lens.size()) actual = high_lens[idx];
    endcase
    checkOutput(name, actual, expected);
  endtask

  task automatic pulseLoad(input int m_v, input int n_v);
    @(negedge clk_in);
    applyStimulus(rst, en, 1'b1, m_v, n_v);
    @(negedge clk_in);
    cfg_load = 1'b0;
  endtask

  task automatic waitBusyLow(input string name);
    for (int g = 0; g < 700 && cfg_busy; g++) @(negedge clk_in);
    checkOutput(name, int'(cfg_busy), 0);
  endtask

  initial begin
    int pat[10];
    int busy_len;
    int n_r;
    int m_r;
    pat = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    waitCycles(3);

    // Defaults from reset: S L L S L L S L L L, 87-cycle frames.
    en = 1'b1;
    waitCycles(2);
    checkOutput("reset_clk_out", int'(clk_out), 0);
    checkOutput("reset_busy", int'(cfg_busy), 0);
    checkOutput("reset_tick", int'(frame_tick), 0);
    clearMonitor();
    rst = 1'b1;
    waitCycles(200);
    for (int i = 0; i < 10; i++) checkEntry($sformatf("default_gap_%0d", i), 0, i, pat[i]);
    checkEntry("frame_tick_gap_0", 1, 0, 87);
    checkEntry("frame_tick_gap_1", 1, 1, 87);
    checkEntry("default_high_0", 2, 0, 4);

    // Rejected loads leave the running config alone.
    pulseLoad(40, 0);
    @(negedge clk_in);
    checkOutput("err_n_zero", int'(cfg_err), 1);
    waitCycles(5);
    pulseLoad(5, 3);
    @(negedge clk_in);
    checkOutput("err_m_small", int'(cfg_err), 1);
    waitCycles(50);

    // Enable drop mid-period, then restart from pattern position 0.
    waitCycles(3);
    en = 1'b0;
    waitCycles(20);
    checkOutput("en_drop_idle", int'(clk_out), 0);
    clearMonitor();
    en = 1'b1;
    waitCycles(40);
    checkEntry("restart_gap_0", 0, 0, 8);
    checkEntry("restart_gap_1", 0, 1, 9);
    checkEntry("restart_gap_2", 0, 2, 9);

    // Mid-frame load of 20/4.
    waitCycles(23);
    pulseLoad(20, 4);
    busy_len = 0;
    for (int g = 0; g < 400 && cfg_busy; g++) begin
      busy_len++;
      @(negedge clk_in);
    end
    checkOutput("busy_len_min", int'(busy_len >= W + 2), 1);
    checkOutput("busy_cleared", int'(cfg_busy), 0);
    waitCycles(3);
    clearMonitor();
    waitCycles(40);
    checkEntry("m20n4_gap_0", 0, 0, 5);
    checkEntry("m20n4_gap_1", 0, 1, 5);
    checkEntry("m20n4_gap_2", 0, 2, 5);
    checkEntry("m20n4_high_0", 2, 0, 2);

    // A second load while busy is ignored.
    pulseLoad(30, 5);
    waitCycles(2);
    pulseLoad(40, 4);
    waitBusyLow("busy_clear_double");
    waitCycles(2);
    clearMonitor();
    waitCycles(40);
    checkEntry("double_gap_0", 0, 0, 6);
    checkEntry("double_high_0", 2, 0, 3);

    // Extreme config M=255, N=1.
    pulseLoad(255, 1);
    waitBusyLow("busy_clear_max");
    clearMonitor();
    waitCycles(600);
    checkEntry("max_gap_0", 0, 0, 255);
    checkEntry("max_high_0", 2, 0, 127);

    // Reset while a swap is pending.
    pulseLoad(240, 2);
    waitBusyLow("busy_clear_long");
    pulseLoad(30, 5);
    waitCycles(W + 2);
    rst = 1'b0;
    @(negedge clk_in);
    checkOutput("pend_reset_clk", int'(clk_out), 0);
    checkOutput("pend_reset_busy", int'(cfg_busy), 0);
    clearMonitor();
    rst = 1'b1;
    waitCycles(30);
    checkEntry("post_reset_gap_0", 0, 0, 8);
    checkEntry("post_reset_gap_1", 0, 1, 9);

    // Randomized enables, loads (valid, invalid, extreme) and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_in);
      cfg_load = 1'b0;
      rst      = 1'b1;
      if ($urandom_range(0, 79) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) begin
        n_r = int'($urandom_range(1, 12));
        case ($urandom_range(0, 7))
          0: begin n_r = 0; m_r = int'($urandom_range(0, 255)); end
          1: m_r = int'($urandom_range(0, 2 * n_r - 1));
          2: begin n_r = 1; m_r = int'($urandom_range(2, 255)); end
          default: m_r = int'($urandom_range(2 * n_r, 2 * n_r + 40));
        endcase
        applyStimulus(1'b1, en, 1'b1, m_r, n_r);
      end
      if ($urandom_range(0, 599) == 0) rst = 1'b0;
    end
    cfg_load = 1'b0;
    rst      = 1'b1;
    waitCycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
